vga_timings: RTL and testbench

- Generates VGA raster timing: a horizontal pixel counter and a vertical line counter, decoded into horizontal sync, vertical sync and active-video flag.
- Sits between the pixel clock domain and the pixel/colour generator.
- The generator uses oH/oV as pixel coordinates and gates colour with oActive.
- Timing is fully parameterised: front porch, sync pulse width, back porch and totals per axis.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 95 +++++++++
 rtl/vga_timings.sv | 120 ++++++++++++
 tb/tb_vga_timings.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared constants and helpers for the VGA raster timing block.
//   - DEF_* : default 640x480@60 timing (25.175 MHz pixel clock).
//   - cntWidth() : counter width needed to hold 0..tot-1.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_PW   = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_H_TOT  = 800;

  // Vertical timing, in lines.
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_PW   = 2;
  localparam int unsigned DEF_V_BP   = 33;
  localparam int unsigned DEF_V_TOT  = 525;

  // 640x480@60 uses negative sync on both axes.
  localparam bit          DEF_EDGE_W = 1'b0;

  // Width of a counter that runs 0..tot-1. A total of 1 or 2 still needs a
  // one-bit register, so clamp at 1 rather than returning $clog2 = 0.
  function automatic int unsigned cntWidth(input int unsigned tot);
    if (tot <= 2) begin
      return 1;
    end
    return $clog2(tot);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis: a wrapping position counter plus decodes of its sync pulse
// and visible region. Used once for the horizontal axis (pixels) and once for
// the vertical axis (lines). The axis is laid out as
//   visible (ACTIVE) | front porch (FP) | sync (PW) | back porch (BP)
// and repeats every TOT counts.
//
// Parameters:
//   ACTIVE, FP, PW, BP : region lengths, in counts
//   TOT                : period; must equal ACTIVE+FP+PW+BP
//   EDGE_W             : level driven on sync while in the sync region
//
// Ports:
//   clk    in   counting clock, rising edge
//   rst    in   synchronous active-high reset; forces count to 0
//   enable in   advance the count on this edge
//   count  out  current position, 0..TOT-1 (the register itself)
//   wrap   out  high on the edge where count goes TOT-1 -> 0
//   sync   out  EDGE_W inside the sync region, ~EDGE_W elsewhere
//   active out  high while count < ACTIVE
//
// No valid/ready handshake: the counter free-runs and every output is valid
// on every clock once reset has been applied.
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_WIDTH,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned PW     = DEF_H_PW,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned TOT    = DEF_H_TOT,
  parameter bit          EDGE_W = DEF_EDGE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic [cntWidth(TOT)-1:0]  count,
  output logic                      wrap,
  output logic                      sync,
  output logic                      active
);

  localparam int unsigned CW = cntWidth(TOT);

  // Region boundaries, pre-sized to the counter width so every compare below
  // is between equal-width operands.
  localparam logic [CW-1:0] LAST       = CW'(TOT - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + PW - 1);

  // Catch inconsistent timing tables at elaboration rather than in the lab.
  generate
    if (ACTIVE + FP + PW + BP != TOT) begin : gBadTotal
      $error("vga_axis_counter: ACTIVE+FP+PW+BP must equal TOT");
    end
    if (PW == 0) begin : gBadPulse
      $error("vga_axis_counter: sync pulse width must be at least 1");
    end
    if (ACTIVE == 0) begin : gBadActive
      $error("vga_axis_counter: visible region must be at least 1");
    end
  endgenerate

  logic atLast;
  logic inSync;

  assign atLast = (count == LAST);

  // Position register. Reset wins over enable so a reset anywhere in the
  // frame lands exactly on 0 with nothing carried over.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      if (atLast) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Decodes of the current count; these are cycle-aligned with count.
  always_comb begin
    wrap   = enable && atLast;
    inSync = (count >= SYNC_FIRST) && (count <= SYNC_LAST);
    sync   = inSync ? EDGE_W : ~EDGE_W;
    active = (count < ACTIVE_END);
  end

endmodule

// File: rtl/vga_timings.sv
// ---------------------------------------------------------------------------
// vga_timings
//
// VGA raster timing generator. A horizontal pixel counter advances every
// clock; a vertical line counter advances when the horizontal counter wraps.
// Sync pulses and the visible-area flag are decoded combinationally from the
// counters, so all outputs describe the same raster position on every clock.
//
// Parameters: WIDTH/H_FP/H_PW/H_BP/H_TOT horizontal timing (clocks),
//             HEIGHT/V_FP/V_PW/V_BP/V_TOT vertical timing (lines),
//             EDGE_W asserted sync level (1 = active-high, 0 = active-low).
//
// Ports:
//   iClk    in   pixel clock, rising edge
//   iRst    in   synchronous active-high reset; position returns to (0,0)
//   oHS     out  horizontal sync
//   oVS     out  vertical sync (spans whole lines)
//   oH      out  horizontal counter / pixel x, 0..H_TOT-1
//   oV      out  vertical counter / line y, 0..V_TOT-1
//   oActive out  high inside the visible area
//
// No valid/ready handshake: the raster free-runs out of reset and the
// downstream colour generator consumes one position per clock.
// ---------------------------------------------------------------------------
module vga_timings
  import vga_timing_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_PW   = DEF_H_PW,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned H_TOT  = DEF_H_TOT,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_PW   = DEF_V_PW,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned V_TOT  = DEF_V_TOT,
  parameter bit          EDGE_W = DEF_EDGE_W
) (
  input  logic                        iClk,
  input  logic                        iRst,
  output logic                        oHS,
  output logic                        oVS,
  output logic [cntWidth(H_TOT)-1:0]  oH,
  output logic [cntWidth(V_TOT)-1:0]  oV,
  output logic                        oActive
);

  localparam int unsigned HW = cntWidth(H_TOT);
  localparam int unsigned VW = cntWidth(V_TOT);

  logic hWrap;
  logic hSync;
  logic hActive;
  logic frameWrap;
  logic vSync;
  logic vActive;

  vga_axis_counter #(
    .ACTIVE (WIDTH),
    .FP     (H_FP),
    .PW     (H_PW),
    .BP     (H_BP),
    .TOT    (H_TOT),
    .EDGE_W (EDGE_W)
  ) uHorz (
    .clk    (iClk),
    .rst    (iRst),
    .enable (1'b1),
    .count  (oH),
    .wrap   (hWrap),
    .sync   (hSync),
    .active (hActive)
  );

  // The line counter only moves on the last pixel of a line, so its wrap is
  // the frame wrap: last pixel of the last line.
  vga_axis_counter #(
    .ACTIVE (HEIGHT),
    .FP     (V_FP),
    .PW     (V_PW),
    .BP     (V_BP),
    .TOT    (V_TOT),
    .EDGE_W (EDGE_W)
  ) uVert (
    .clk    (iClk),
    .rst    (iRst),
    .enable (hWrap),
    .count  (oV),
    .wrap   (frameWrap),
    .sync   (vSync),
    .active (vActive)
  );

  assign oHS     = hSync;
  assign oVS     = vSync;
  assign oActive = hActive & vActive;

  // Structural invariants of the raster, checked in simulation only.
  frameWrapToOrigin: assert property (
    @(posedge iClk) disable iff (iRst)
    frameWrap |=> (oH == '0) && (oV == '0)
  );

  hInRange: assert property (
    @(posedge iClk) disable iff (iRst)
    oH <= HW'(H_TOT - 1)
  );

  vInRange: assert property (
    @(posedge iClk) disable iff (iRst)
    oV <= VW'(V_TOT - 1)
  );

  vHoldsWithinLine: assert property (
    @(posedge iClk) disable iff (iRst)
    !hWrap |=> $stable(oV)
  );

endmodule

// File: tb/tb_vga_timings.sv
// ---------------------------------------------------------------------------
// tb_vga_timings
//
// Small raster (12x12, visible 5x5, sync at 7..9 on both axes, active-high
// sync). The driver issues one clock per tick() call and pushes the raster
// position expected after that edge; the monitor pops and compares on every
// falling edge. Region tallies over the first frame after reset release are
// checked against hand-counted totals at the end.
// ---------------------------------------------------------------------------
module tb_vga_timings;

  localparam int unsigned WIDTH  = 5;
  localparam int unsigned H_FP   = 2;
  localparam int unsigned H_PW   = 3;
  localparam int unsigned H_BP   = 2;
  localparam int unsigned H_TOT  = 12;
  localparam int unsigned HEIGHT = 5;
  localparam int unsigned V_FP   = 2;
  localparam int unsigned V_PW   = 3;
  localparam int unsigned V_BP   = 2;
  localparam int unsigned V_TOT  = 12;
  localparam bit          EDGE_W = 1'b1;

  // ---------------- clock / reset ----------------
  // Clock starts high so rising edges fall at 20, 40, 60 ns; reset drops at
  // the 70 ns falling edge, i.e. after 3.5 cycles.
  logic       iClk = 1'b1;
  logic       iRst = 1'b1;
  logic       oHS;
  logic       oVS;
  logic       oActive;
  logic [3:0] oH;
  logic [3:0] oV;

  always #10 iClk = ~iClk;

  vga_timings #(
    .WIDTH  (WIDTH),
    .H_FP   (H_FP),
    .H_PW   (H_PW),
    .H_BP   (H_BP),
    .H_TOT  (H_TOT),
    .HEIGHT (HEIGHT),
    .V_FP   (V_FP),
    .V_PW   (V_PW),
    .V_BP   (V_BP),
    .V_TOT  (V_TOT),
    .EDGE_W (EDGE_W)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .oHS     (oHS),
    .oVS     (oVS),
    .oH      (oH),
    .oV      (oV),
    .oActive (oActive)
  );

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];   // {h[3:0], v[3:0], hs, vs, active}
  bit          win_q[$];   // item belongs to the first frame after release
  int          tests = 0;
  int          fails = 0;
  int          mh = 0;
  int          mv = 0;
  int          hsLine0 = 0;
  int          vsCnt = 0;
  int          actCnt = 0;

  // Hand-written decode for this raster: sync at 7,8,9; visible 0..4.
  function automatic logic [10:0] expectAt(input int h, input int v);
    logic hs;
    logic vs;
    logic act;
    hs  = (h == 7) || (h == 8) || (h == 9);
    vs  = (v == 7) || (v == 8) || (v == 9);
    act = (h < 5) && (v < 5);
    return {4'(h), 4'(v), hs, vs, act};
  endfunction

  // ---------------- driver ----------------
  // Drive iRst, take one rising edge, advance the position model and queue
  // what the DUT must show after that edge.
  task automatic tick(input logic rst, input bit win);
    iRst = rst;
    @(posedge iClk);
    if (rst) begin
      mh = 0;
      mv = 0;
    end else if (mh == 11) begin
      mh = 0;
      mv = (mv == 11) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    exp_q.push_back(expectAt(mh, mv));
    win_q.push_back(win);
    @(negedge iClk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge iClk) begin
    logic [10:0] e;
    logic [10:0] a;
    bit          w;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = win_q.pop_front();
      a = {oH, oV, oHS, oVS, oActive};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL raster @%0t: got H=%0d V=%0d hs=%b vs=%b act=%b, want H=%0d V=%0d hs=%b vs=%b act=%b",
                 $time, a[10:7], a[6:3], a[2], a[1], a[0],
                 e[10:7], e[6:3], e[2], e[1], e[0]);
      end
      if (w) begin
        if (oHS === 1'b1 && oV === 4'd0) hsLine0++;
        if (oVS === 1'b1) vsCnt++;
        if (oActive === 1'b1) actCnt++;
      end
    end
  end

  task automatic checkCount(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held across three rising edges: (0,0), hs=vs=0, active=1.
    repeat (3) tick(1'b1, 1'b0);

    // One full frame after release: H 1..11,0 per line, V steps on H wrap,
    // and the 144th edge lands back on (0,0).
    for (int i = 0; i < 144; i++) tick(1'b0, 1'b1);

    // Keep running to 250 clocks total to see the pattern repeat.
    for (int i = 0; i < 106; i++) tick(1'b0, 1'b0);

    // Walk to (H=6, V=8) inside the vertical sync, bounded.
    for (int i = 0; i < 200; i++) begin
      if (mh == 6 && mv == 8) break;
      tick(1'b0, 1'b0);
    end
    tests++;
    if (!(mh == 6 && mv == 8)) begin
      fails++;
      $display("FAIL seek_mid_frame: reached H=%0d V=%0d, want H=6 V=8", mh, mv);
    end

    // Mid-frame reset for one edge, then counting resumes from H=1.
    tick(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);

    #1;
    checkCount("hs_cycles_line0", hsLine0, 3);
    checkCount("vs_cycles_frame", vsCnt, 36);
    checkCount("active_cycles_frame", actCnt, 25);
    checkCount("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the run is a few hundred clocks; anything far beyond is a hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
